// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader.
//   WORD_W  : default assembled word width
//   state_t : loader FSM states (IDLE / SHIFT / HOLD)
package serial_word_loader_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_word_loader_sipo_shift_reg.sv
// Indexed bit-write register used to assemble the serial word.
//   clk     : clock
//   res     : asynchronous active-high clear
//   wr_en   : write bit_in into position wr_idx this cycle
//   wr_idx  : target bit index (0 = first bit of the word)
//   bit_in  : serial data bit
//   q       : register contents, q[0] = first bit received
module sipo_shift_reg #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             bit_in,
  output logic [0:WIDTH-1] q
);

  // Decoded per-bit enables keep the index compare at the counter width,
  // which may be wider than log2(WIDTH).
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      q <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (wr_idx == IDX_W'(i)) q[i] <= bit_in;
      end
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel front end feeding the 32-bit word register.
//   clk        : clock, all state changes on posedge
//   res        : asynchronous active-high reset
//   ser_in     : serial data bit
//   ser_valid  : ser_in valid this cycle
//   flush      : synchronous abort of partial/held word, clears overrun
//   word_ready : downstream accepts word_out this cycle (HOLD only)
//   word_out   : assembled word, word_out[0] = first bit received
//   word_valid : word_out complete and held
//   busy       : word in progress (SHIFT)
//   bit_count  : bits collected in current word
//   overrun    : sticky, a bit arrived in HOLD without acceptance
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             flush,
  input  logic             word_ready,
  output logic [0:WIDTH-1] word_out,
  output logic             word_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ser_valid) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            cnt_d   = CNT_W'(1);
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_valid) begin
            wr_en = 1'b1;
            if (cnt_q >= CNT_W'(WIDTH - 1)) begin
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (word_ready) begin
            // Accept and, if a bit arrives in the same cycle, start the next word with it.
            if (ser_valid) begin
              wr_en   = 1'b1;
              wr_idx  = '0;
              cnt_d   = CNT_W'(1);
              state_d = S_SHIFT;
            end else begin
              state_d = S_IDLE;
            end
          end else if (ser_valid) begin
            ovr_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  sipo_shift_reg #(
    .WIDTH(WIDTH),
    .IDX_W(CNT_W)
  ) u_sipo (
    .clk   (clk),
    .res   (res),
    .wr_en (wr_en),
    .wr_idx(wr_idx),
    .bit_in(ser_in),
    .q     (word_out)
  );

  assign word_valid = (state_q == S_HOLD);
  assign busy       = (state_q == S_SHIFT);
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

  localparam int W = 32;
  localparam int CW = 6;

  logic          clk;
  logic          res;
  logic          ser_in;
  logic          ser_valid;
  logic          flush;
  logic          word_ready;
  logic [0:W-1]  word_out;
  logic          word_valid;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  logic [0:W-1] sb_q[$];
  logic [0:W-1] exp_w;

  serial_word_loader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .res       (res),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .flush     (flush),
    .word_ready(word_ready),
    .word_out  (word_out),
    .word_valid(word_valid),
    .busy      (busy),
    .bit_count (bit_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Before each edge: a handshake that completes this edge pops the scoreboard.
  task automatic tick();
    if (word_valid && word_ready && !flush) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", word_out);
      end else begin
        chk("sb_word", word_out, sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [0:W-1] w, input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_in    = w[i];
      tick();
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic send_word(input logic [0:W-1] w, input bit push);
    send_bits(w, W);
    if (push) sb_q.push_back(w);
  endtask

  initial begin
    res = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b0;
    chk("rst_word_out", word_out, 32'h0);
    chk("rst_valid", word_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", bit_count, 0);
    chk("rst_overrun", overrun, 0);

    // 1: async reset mid-SHIFT
    send_bits(32'hFFFF_FFFF, 10);
    chk("t1_busy", busy, 1);
    chk("t1_count", bit_count, 10);
    #2 res = 1'b1;
    #1;
    chk("t1_async_word", word_out, 32'h0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_count", bit_count, 0);
    chk("t1_async_valid", word_valid, 0);
    res = 1'b0;
    @(posedge clk);
    #1;

    // 2: single word, ready high throughout
    word_ready = 1'b1;
    send_word(32'hA5A5_F00F, 1'b1);
    chk("t2_valid", word_valid, 1);
    chk("t2_word", word_out, 32'hA5A5_F00F);
    tick();
    chk("t2_valid_1cyc", word_valid, 0);
    chk("t2_busy", busy, 0);

    // 3: backpressure
    word_ready = 1'b0;
    exp_w = 32'h1234_5678;
    send_word(exp_w, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_hold", word_valid, 1);
      chk("t3_word_hold", word_out, exp_w);
      tick();
    end
    word_ready = 1'b1;
    tick();
    chk("t3_valid_after", word_valid, 0);

    // 4: overrun
    word_ready = 1'b0;
    exp_w = 32'hDEAD_BEEF;
    send_word(exp_w, 1'b1);
    send_bits(32'h0000_0000, 3);
    chk("t4_overrun", overrun, 1);
    chk("t4_word_kept", word_out, exp_w);
    chk("t4_valid", word_valid, 1);
    word_ready = 1'b1;
    tick();
    chk("t4_overrun_sticky", overrun, 1);
    send_bits(32'h8000_0000, 1);
    chk("t4_next_count", bit_count, 1);
    ser_valid = 1'b0;
    tick();
    tick();
    chk("t4_gap_count", bit_count, 1);
    // finish that word: bits 1..31 of 0x8000_0001 after the leading 1
    send_bits(32'h0000_0002, 31);
    sb_q.push_back(32'h8000_0001);
    tick();

    // flush clears overrun
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_overrun_clr", overrun, 0);

    // 5: accept and new bit in the same cycle
    word_ready = 1'b0;
    send_word(32'h0F0F_3C3C, 1'b1);
    word_ready = 1'b1;
    ser_valid = 1'b1;
    ser_in = 1'b1;
    tick();
    ser_valid = 1'b0;
    chk("t5_overrun", overrun, 0);
    chk("t5_busy", busy, 1);
    chk("t5_count", bit_count, 1);
    chk("t5_valid", word_valid, 0);
    chk("t5_bit0", word_out[0], 1);
    send_bits(32'h6000_0000, 31);
    sb_q.push_back(32'hB000_0000);
    tick();

    // back-to-back, ready tied high: zero idle cycles between words
    send_word(32'hCAFE_0001, 1'b1);
    send_word(32'h0123_4567, 1'b1);
    chk("b2b_valid", word_valid, 1);
    tick();

    // 6: flush mid-word at bit_count=17
    send_bits(32'hFFFF_FFFF, 17);
    chk("t6_count17", bit_count, 17);
    flush = 1'b1;
    ser_valid = 1'b1;
    ser_in = 1'b1;
    tick();
    flush = 1'b0;
    ser_valid = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_count", bit_count, 0);
    chk("t6_valid", word_valid, 0);

    // flush during HOLD with ready high: no transfer
    word_ready = 1'b0;
    exp_w = 32'h5555_AAAA;
    send_word(exp_w, 1'b0);
    chk("t6_hold_valid", word_valid, 1);
    word_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_hold_flush_valid", word_valid, 0);
    chk("t6_hold_flush_busy", busy, 0);
    chk("t6_word_not_cleared", word_out, exp_w);
    tick();
    chk("t6_idle_valid", word_valid, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
